spi_rcbuf_drain: RTL and testbench
==================================

// Module: spi_rcbuf_drain
// PURPOSE
//  SysClk-domain reader for the 32-bit port B of the SPI receive buffer memory (spiMemRc).
//  After a start pulse it sweeps a contiguous word range (with address wrap-around) and
//  streams the words out over a valid/ready interface. It keeps a running checksum for host
//  bring-up and loopback checks. It drains what spiifc wrote through port A, replacing the
//  fixed-address probe of the receive memory.
// PARAMETERS
//  ADDR_W   10   word-address width of memory port B (depth 2**ADDR_W words)
//  DATA_W   32   word width of memory port B and of outData/checksum
// PORTS
//  SysClk     in   1        system clock; all logic on rising edge
//  Reset      in   1        synchronous, active-high reset
//  start      in   1        1-cycle request to begin a drain; ignored while busy=1
//  startAddr  in   ADDR_W   first word address, sampled with an accepted start
//  wordCount  in   ADDR_W+1 words to read, 0..2**ADDR_W, sampled with an accepted start
//  memEn      out  1        port B enable (enb); high only in cycles that issue a read
//  memAddr    out  ADDR_W   port B address (addrb)
//  memData    in   DATA_W   port B read data (doutb); valid 1 cycle after the memEn cycle
//  outValid   out  1        outData holds a word
//  outData    out  DATA_W   streamed word
//  outLast    out  1        qualifies the final word of the drain (meaningful with outValid)
//  outReady   in   1        consumer accepts the word; transfer = outValid & outReady
//  busy       out  1        drain in progress
//  done       out  1        1-cycle pulse when a drain completes
//  checksum   out  DATA_W   sum mod 2**DATA_W of transferred words; cleared on accepted start
//  wordsSent  out  ADDR_W+1 count of transferred words in the current/last drain
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, output FIFO empty, in-flight read discarded.
//  Reset mid-drain aborts immediately. No done pulse. checksum and wordsSent are cleared.
//  FSM: IDLE -> RUN on start&!busy; RUN -> FIN after the last word's transfer.
//   FIN -> IDLE unconditionally, with done=1 for that one cycle. busy=1 in RUN and FIN.
//  start with wordCount=0: RUN is skipped (IDLE->FIN). done pulses 1 cycle later. No memEn.
//  Accepted start clears checksum and wordsSent. It loads rdAddr=startAddr,
//   issueLeft=wordCount and sendLeft=wordCount.
//  Read issue (RUN only): memEn=1, memAddr=rdAddr when issueLeft!=0 and credit is available.
//   Credit rule: fifoCount + inFlight - pop < 2, where pop = the transfer this cycle.
//   On issue, rdAddr increments and wraps 2**ADDR_W-1 -> 0, and issueLeft decrements.
//  Read return: inFlight is a 1-bit flag set on issue.
//   The cycle after issue, memData is pushed into a 2-entry FIFO.
//   The credit rule guarantees the FIFO never overflows.
//  Output: outValid = FIFO non-empty; outData = FIFO head.
//   outLast=1 when the head is the final word (sendLeft==1).
//   outData/outLast hold stable while outValid&!outReady.
//  Transfer: pop the FIFO, checksum += outData, wordsSent++, sendLeft--.
//  Latency: start sampled at edge E0 -> memEn high in cycle E0..E1 -> outValid high after E2.
//   With outReady held high, throughput is 1 word/cycle.
//   N words take N+3 edges from start to done.
//  Back-pressure: with outReady low, at most 2 reads are outstanding (FIFO+inFlight).
//   memEn stays low until space frees.
//  Simultaneous push and pop on a full or one-entry FIFO is legal; occupancy is unchanged.
//  start while busy: ignored, no state change. start in the same cycle as done: ignored.
//  wordCount=2**ADDR_W with any startAddr reads every word exactly once, wrapping.
//  checksum/wordsSent hold their final value after done until the next accepted start.
// TESTING
//  1 Memory preloaded word[i]=i. start, startAddr=0, wordCount=4, outReady=1
//    -> outData 0,1,2,3 on consecutive cycles; outLast only on 3; checksum=6;
//    done 7 edges after start.
//  2 startAddr=0x3FE, wordCount=4 -> memAddr 3FE,3FF,000,001; data in that order.
//  3 wordCount=8, outReady toggled 1,0,0,1,...
//    -> no word lost or duplicated; outData stable while stalled; memEn never has >2 outstanding.
//  4 wordCount=0 -> busy for 1 cycle, done pulse, memEn never high, checksum=0.
//  5 start repeated during a 16-word drain -> ignored; exactly 16 transfers, one done.
//    Reset asserted mid-drain -> next cycle all outputs 0, no done.
//  6 All 1024 words =32'hFFFF_FFFF, wordCount=1024 -> checksum=32'hFFFF_FC00, wordsSent=1024.

Source files
------------

// File: rtl/spi_rcbuf_drain.sv
// SysClk-domain drain of spiMemRc port B: sweeps a wrapping word range
// and streams it over valid/ready with a running checksum.
module spi_rcbuf_drain #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              SysClk,
    input  logic              Reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] startAddr,
    input  logic [ADDR_W:0]   wordCount,
    output logic              memEn,
    output logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memData,
    output logic              outValid,
    output logic [DATA_W-1:0] outData,
    output logic              outLast,
    input  logic              outReady,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum,
    output logic [ADDR_W:0]   wordsSent
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIN  = 2'd2;

    localparam logic [ADDR_W:0] CNT_ZERO = '0;
    localparam logic [ADDR_W:0] CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_rdAddr;
    logic [ADDR_W:0]   r_issueLeft;
    logic [ADDR_W:0]   r_sendLeft;
    logic              r_inFlight;
    logic [DATA_W-1:0] r_fifo [2];
    logic              r_wrPtr;
    logic              r_rdPtr;
    logic [1:0]        r_count;
    logic [DATA_W-1:0] r_checksum;
    logic [ADDR_W:0]   r_wordsSent;

    logic              w_accept;
    logic              w_valid;
    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_occ;
    logic [2:0]        w_limit;
    logic              w_credit;
    logic              w_issue;
    logic              w_lastXfer;

    assign w_accept   = start && (r_state == S_IDLE);
    assign w_valid    = (r_count != 2'd0);
    assign w_pop      = w_valid && outReady;
    assign w_push     = r_inFlight;

    // Reads already committed (queued + returning) minus the word leaving now.
    assign w_occ      = {1'b0, r_count} + {2'b00, r_inFlight};
    assign w_limit    = 3'd2 + {2'b00, w_pop};
    assign w_credit   = (w_occ < w_limit);

    assign w_issue    = (r_state == S_RUN) && (r_issueLeft != CNT_ZERO)
                        && w_credit;
    assign w_lastXfer = w_pop && (r_sendLeft == CNT_ONE);

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            r_state     <= S_IDLE;
            r_rdAddr    <= '0;
            r_issueLeft <= '0;
            r_sendLeft  <= '0;
            r_inFlight  <= 1'b0;
        end else begin
            r_inFlight <= w_issue;
            if (w_issue) begin
                r_rdAddr    <= r_rdAddr + 1'b1;
                r_issueLeft <= r_issueLeft - CNT_ONE;
            end
            if (w_pop) begin
                r_sendLeft <= r_sendLeft - CNT_ONE;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rdAddr    <= startAddr;
                        r_issueLeft <= wordCount;
                        r_sendLeft  <= wordCount;
                        r_state     <= (wordCount == CNT_ZERO) ? S_FIN : S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_lastXfer) begin
                        r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
            r_count <= 2'd0;
        end else begin
            if (w_push) begin
                r_wrPtr <= ~r_wrPtr;
            end
            if (w_pop) begin
                r_rdPtr <= ~r_rdPtr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: outData is masked while the FIFO is empty.
    always_ff @(posedge SysClk) begin
        if (w_push) begin
            r_fifo[r_wrPtr] <= memData;
        end
    end

    always_ff @(posedge SysClk) begin
        if (Reset) begin
            r_checksum  <= '0;
            r_wordsSent <= '0;
        end else if (w_accept) begin
            r_checksum  <= '0;
            r_wordsSent <= '0;
        end else if (w_pop) begin
            r_checksum  <= r_checksum + r_fifo[r_rdPtr];
            r_wordsSent <= r_wordsSent + CNT_ONE;
        end
    end

    assign memEn     = w_issue;
    assign memAddr   = r_rdAddr;
    assign outValid  = w_valid;
    assign outData   = w_valid ? r_fifo[r_rdPtr] : '0;
    assign outLast   = w_valid && (r_sendLeft == CNT_ONE);
    assign busy      = (r_state != S_IDLE);
    assign done      = (r_state == S_FIN);
    assign checksum  = r_checksum;
    assign wordsSent = r_wordsSent;

endmodule

// File: tb/tb_spi_rcbuf_drain.sv
// Directed bench for spi_rcbuf_drain with a behavioural port-B memory
// and a negedge monitor recording issues, transfers and stalls.
module tb_spi_rcbuf_drain;

    logic        clk;
    logic        Reset;
    logic        start;
    logic [9:0]  startAddr;
    logic [10:0] wordCount;
    logic        memEn;
    logic [9:0]  memAddr;
    logic [31:0] memData;
    logic        outValid;
    logic [31:0] outData;
    logic        outLast;
    logic        outReady;
    logic        busy;
    logic        done;
    logic [31:0] checksum;
    logic [10:0] wordsSent;

    int checks;
    int errors;

    logic [31:0] mem [1024];

    int          issued;
    int          xfers;
    int          dones;
    int          maxOut;
    int          stallViol;
    int          lastCnt;
    int          lastIdx;
    int          hits [1024];
    logic [31:0] dataQ [$];
    logic [9:0]  addrQ [$];
    logic        prevStall;
    logic [31:0] prevData;
    logic        prevLast;

    spi_rcbuf_drain #(.ADDR_W(10), .DATA_W(32)) dut (
        .SysClk    (clk),
        .Reset     (Reset),
        .start     (start),
        .startAddr (startAddr),
        .wordCount (wordCount),
        .memEn     (memEn),
        .memAddr   (memAddr),
        .memData   (memData),
        .outValid  (outValid),
        .outData   (outData),
        .outLast   (outLast),
        .outReady  (outReady),
        .busy      (busy),
        .done      (done),
        .checksum  (checksum),
        .wordsSent (wordsSent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (memEn) memData <= mem[memAddr];
    end

    always @(negedge clk) begin
        if (Reset) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                if (!(outValid && outData == prevData && outLast == prevLast))
                    stallViol++;
            end
            if (memEn) begin
                issued++;
                addrQ.push_back(memAddr);
                hits[memAddr]++;
            end
            if (outValid && outReady) begin
                xfers++;
                dataQ.push_back(outData);
                if (outLast) begin
                    lastCnt++;
                    lastIdx = xfers;
                end
            end
            if (done) dones++;
            if (issued - xfers > maxOut) maxOut = issued - xfers;
            prevStall = outValid && !outReady;
            prevData  = outData;
            prevLast  = outLast;
        end
    end

    task automatic clear_mon();
        issued = 0; xfers = 0; dones = 0; maxOut = 0;
        stallViol = 0; lastCnt = 0; lastIdx = 0;
        dataQ.delete();
        addrQ.delete();
        for (int i = 0; i < 1024; i++) hits[i] = 0;
    endtask

    task automatic do_start(input logic [9:0] a, input logic [10:0] n);
        @(posedge clk); #1;
        startAddr = a;
        wordCount = n;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    // Edges counted from the cycle start was driven; done seen after edge e.
    task automatic wait_done(input int limit, output int e);
        e = 1;
        while (!done && e < limit) begin
            @(posedge clk); #1;
            e++;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout: no done within %0d edges", limit);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({memEn, memAddr, outValid, outData, outLast, busy, done,
             checksum, wordsSent} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b memEn=%b outValid=%b cs=%h ws=%0d, want all 0",
                     busy, memEn, outValid, checksum, wordsSent);
        end
        Reset = 1'b0;
    endtask

    task automatic test_basic();
        int e;
        for (int i = 0; i < 1024; i++) mem[i] = i;
        outReady = 1'b1;
        clear_mon();
        do_start(10'd0, 11'd4);
        wait_done(50, e);
        checks++;
        if (e !== 7) begin
            errors++; $display("FAIL basic_done_latency: got %0d edges, want 7", e);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dataQ.size() != 4) begin
            errors++; $display("FAIL basic_count: got %0d words, want 4", dataQ.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (dataQ[i] !== 32'(i)) begin
                    errors++; $display("FAIL basic_data[%0d]: got %h, want %h", i, dataQ[i], i);
                end
            end
        end
        checks++;
        if (lastCnt !== 1 || lastIdx !== 4) begin
            errors++; $display("FAIL basic_last: got cnt=%0d idx=%0d, want 1/4", lastCnt, lastIdx);
        end
        checks++;
        if (checksum !== 32'd6) begin
            errors++; $display("FAIL basic_checksum: got %h, want 6", checksum);
        end
        checks++;
        if (wordsSent !== 11'd4 || dones !== 1 || busy !== 1'b0) begin
            errors++; $display("FAIL basic_status: got ws=%0d dones=%0d busy=%b, want 4/1/0",
                               wordsSent, dones, busy);
        end
    endtask

    task automatic test_wrap();
        int e;
        logic [9:0] expA [4];
        expA[0] = 10'h3FE; expA[1] = 10'h3FF; expA[2] = 10'h000; expA[3] = 10'h001;
        clear_mon();
        do_start(10'h3FE, 11'd4);
        wait_done(50, e);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (addrQ.size() != 4 || dataQ.size() != 4) begin
            errors++; $display("FAIL wrap_count: got %0d addrs %0d words, want 4/4",
                               addrQ.size(), dataQ.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (addrQ[i] !== expA[i] || dataQ[i] !== {22'd0, expA[i]}) begin
                    errors++; $display("FAIL wrap_seq[%0d]: got addr %h data %h, want %h",
                                       i, addrQ[i], dataQ[i], expA[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int k;
        clear_mon();
        outReady = 1'b0;
        do_start(10'h20, 11'd8);
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (issued !== 2 || xfers !== 0 || outValid !== 1'b1 || outData !== 32'h20) begin
            errors++; $display("FAIL bp_stalled: got issued=%0d xfers=%0d valid=%b data=%h, want 2/0/1/20",
                               issued, xfers, outValid, outData);
        end
        k = 0;
        while (!done && k < 200) begin
            outReady = (k % 4 == 0) || (k % 4 == 3);
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (!done) begin
            errors++; $display("FAIL bp_timeout: no done after %0d cycles", k);
        end
        outReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dataQ.size() != 8) begin
            errors++; $display("FAIL bp_count: got %0d words, want 8", dataQ.size());
        end else begin
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (dataQ[i] !== 32'h20 + 32'(i)) begin
                    errors++; $display("FAIL bp_data[%0d]: got %h, want %h", i, dataQ[i], 32'h20 + i);
                end
            end
        end
        checks++;
        if (stallViol !== 0 || maxOut > 2) begin
            errors++; $display("FAIL bp_stability: got viol=%0d maxOut=%0d, want 0/<=2", stallViol, maxOut);
        end
        checks++;
        if (checksum !== 32'd284 || wordsSent !== 11'd8 || lastIdx !== 8) begin
            errors++; $display("FAIL bp_totals: got cs=%0d ws=%0d lastIdx=%0d, want 284/8/8",
                               checksum, wordsSent, lastIdx);
        end
    endtask

    task automatic test_zero();
        clear_mon();
        outReady = 1'b1;
        do_start(10'h55, 11'd0);
        checks++;
        if (busy !== 1'b1 || done !== 1'b1) begin
            errors++; $display("FAIL zero_fin: got busy=%b done=%b, want 1/1", busy, done);
        end
        startAddr = 10'h100;
        wordCount = 11'd3;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL start_on_done: got busy=%b done=%b, want 0/0", busy, done);
        end
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (issued !== 0 || dones !== 1 || checksum !== 32'd0 || wordsSent !== 11'd0) begin
            errors++; $display("FAIL zero_totals: got issued=%0d dones=%0d cs=%h ws=%0d, want 0/1/0/0",
                               issued, dones, checksum, wordsSent);
        end
    endtask

    task automatic test_restart();
        int e;
        clear_mon();
        do_start(10'h10, 11'd16);
        for (int i = 0; i < 5; i++) begin
            startAddr = 10'h200;
            wordCount = 11'd3;
            start     = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        wait_done(100, e);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (xfers !== 16 || dones !== 1 || wordsSent !== 11'd16) begin
            errors++; $display("FAIL restart_counts: got xfers=%0d dones=%0d ws=%0d, want 16/1/16",
                               xfers, dones, wordsSent);
        end
        checks++;
        if (dataQ.size() != 16 || dataQ[0] !== 32'h10 || dataQ[dataQ.size()-1] !== 32'h1F) begin
            errors++; $display("FAIL restart_data: got %0d words first %h, want 16 from 10",
                               dataQ.size(), dataQ.size() ? dataQ[0] : 32'hx);
        end
    endtask

    task automatic test_abort();
        int issuedAtReset;
        clear_mon();
        do_start(10'h40, 11'd16);
        repeat (5) @(posedge clk);
        #1;
        Reset = 1'b1;
        @(posedge clk); #1;
        issuedAtReset = issued;
        checks++;
        if ({memEn, memAddr, outValid, outData, outLast, busy, done,
             checksum, wordsSent} !== '0) begin
            errors++; $display("FAIL abort_outputs: got busy=%b memEn=%b valid=%b cs=%h ws=%0d, want all 0",
                               busy, memEn, outValid, checksum, wordsSent);
        end
        Reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        checks++;
        if (dones !== 0 || busy !== 1'b0 || issued !== issuedAtReset) begin
            errors++; $display("FAIL abort_quiet: got dones=%0d busy=%b issues=%0d, want 0/0/%0d",
                               dones, busy, issued, issuedAtReset);
        end
    endtask

    task automatic test_full();
        int e;
        int bad;
        for (int i = 0; i < 1024; i++) mem[i] = 32'hFFFF_FFFF;
        clear_mon();
        outReady = 1'b1;
        do_start(10'h155, 11'd1024);
        wait_done(1200, e);
        checks++;
        if (e !== 1027) begin
            errors++; $display("FAIL full_latency: got %0d edges, want 1027", e);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (checksum !== 32'hFFFF_FC00 || wordsSent !== 11'd1024) begin
            errors++; $display("FAIL full_totals: got cs=%h ws=%0d, want FFFFFC00/1024",
                               checksum, wordsSent);
        end
        bad = 0;
        for (int i = 0; i < 1024; i++) if (hits[i] != 1) bad++;
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL full_coverage: got %0d addresses not read exactly once, want 0", bad);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        Reset     = 1'b1;
        start     = 1'b0;
        startAddr = '0;
        wordCount = '0;
        outReady  = 1'b0;
        prevStall = 1'b0;
        prevData  = '0;
        prevLast  = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        clear_mon();
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero();
        test_restart();
        test_abort();
        test_full();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
